// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; divide stays iterative.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_f3;
    logic              r_neg;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb;
    logic              r_valid;
    logic [XLEN-1:0]   r_result;
    logic              w_signed_a, w_signed_b, w_sa, w_sb, w_div0, w_ovf, w_ge;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_spec, w_rem_sub, w_dw, w_res;
    logic [XLEN:0]     w_mul_sum, w_rem_sh;
    logic [2*XLEN-1:0] w_step, w_prod;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fp;
    logic [XLEN-1:0]   w_fast;
`endif
    always_comb begin
        w_signed_a = funct3[2] ? ~funct3[0] : (funct3[1] ^ funct3[0]);
        w_signed_b = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
        w_sa       = w_signed_a & a[XLEN-1];
        w_sb       = w_signed_b & b[XLEN-1];
        w_abs_a    = w_sa ? -a : a;
        w_abs_b    = w_sb ? -b : b;
        w_div0     = funct3[2] && (b == '0);
        w_ovf      = funct3[2] && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        w_spec     = w_div0 ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
`ifdef MULDIV_FAST_MUL_EN
        // Low 2*XLEN bits of the sign-extended product are exact for all four multiply flavours
        w_fp       = {{XLEN{w_sa}}, a} * {{XLEN{w_sb}}, b};
        w_fast     = (funct3 == 3'd0) ? w_fp[XLEN-1:0] : w_fp[2*XLEN-1:XLEN];
`endif
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opb : {XLEN{1'b0}})};
        w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
        w_ge       = w_rem_sh >= {1'b0, r_opb};
        w_rem_sub  = w_rem_sh[XLEN-1:0] - r_opb;
        w_step     = r_f3[2] ? {(w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge}
                             : {w_mul_sum, r_acc[XLEN-1:1]};
        w_prod     = r_neg ? -w_step : w_step;
        w_dw       = r_f3[1] ? w_step[2*XLEN-1:XLEN] : w_step[XLEN-1:0];
        w_res      = r_f3[2] ? (r_neg ? -w_dw : w_dw)
                             : ((r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
    end
    assign busy   = ((r_state == IDLE) && start && !kill) || (r_state == BUSY);
    assign valid  = r_valid;
    assign result = r_result;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_valid  <= 1'b0;
            r_result <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: if (start && !kill) begin
                    r_f3  <= funct3;
                    r_cnt <= '0;
                    // Remainder takes the dividend's sign; everything else the product/quotient sign
                    r_neg <= (funct3[2] && funct3[1]) ? w_sa : (w_sa ^ w_sb);
                    r_acc <= {{XLEN{1'b0}}, (funct3[2] ? w_abs_a : w_abs_b)};
                    r_opb <= funct3[2] ? w_abs_b : w_abs_a;
                    if (w_div0 || w_ovf) begin
                        r_result <= w_spec;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!funct3[2]) begin
                        r_result <= w_fast;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end
`endif
                    else r_state <= BUSY;
                end
                BUSY: if (kill) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(XLEN-1)) begin
                        r_result <= w_res;
                        r_valid  <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vector table plus kill/reset/held-start sequences for muldiv_seq.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, valid;
    logic [31:0] result;
    int checks = 0;
    int errors = 0;
`ifdef MULDIV_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = 33;
`endif
    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t tv[19];

    muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .a(a), .b(b),
        .kill(kill), .busy(busy), .valid(valid), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Issue one op at C0 and observe 60 cycles: busy-cycle count, first valid cycle, valid count
    task automatic run(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int vcyc, output int bcnt, output int vcnt);
        @(posedge clk); #1;
        funct3 = f; a = x; b = y; start = 1'b1;
        #1;
        bcnt = busy ? 1 : 0;
        vcyc = -1; vcnt = 0; res = 'x;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            if (busy) bcnt++;
            if (valid) begin
                vcnt++;
                if (vcyc < 0) begin vcyc = n; res = result; end
            end
        end
    endtask

    initial begin
        logic [31:0] res;
        int vcyc, bcnt, vcnt, vseen;
        tv[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, ML};
        tv[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML};
        tv[2]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, ML};
        tv[3]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, ML};
        tv[4]  = '{3'd0, 32'h12345678, 32'h10,       32'h23456780, ML};
        tv[5]  = '{3'd1, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, ML};
        tv[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       33};
        tv[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        33};
        tv[8]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        tv[9]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        tv[10] = '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        tv[11] = '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        33};
        tv[12] = '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33};
        tv[13] = '{3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
        tv[14] = '{3'd4, 32'd123,      32'd0,        32'hFFFFFFFF, 1};
        tv[15] = '{3'd7, 32'd5,        32'd0,        32'd5,        1};
        tv[16] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        tv[17] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        tv[18] = '{3'd5, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", {31'd0, valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset result", result, 32'd0);
        rst = 1'b0;

        foreach (tv[i]) begin
            run(tv[i].f, tv[i].a, tv[i].b, res, vcyc, bcnt, vcnt);
            chk($sformatf("vec%0d result", i), res, tv[i].exp);
            chk($sformatf("vec%0d valid cycle", i), vcyc, tv[i].lat);
            chk($sformatf("vec%0d busy cycles", i), bcnt, tv[i].lat);
            chk($sformatf("vec%0d valid count", i), vcnt, 1);
        end

        // Kill at C10 of a divide, then a MUL issued at C12
        @(posedge clk); #1;
        funct3 = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
        vseen = 0;
        for (int n = 1; n <= 11; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            kill = (n == 10);
            #1;
            if (valid) vseen++;
            if (n == 10) chk("kill busy C10", {31'd0, busy}, 32'd1);
        end
        chk("kill busy C11", {31'd0, busy}, 32'd0);
        chk("kill no valid", vseen, 0);
        run(3'd0, 32'd7, 32'hFFFFFFFD, res, vcyc, bcnt, vcnt);
        chk("post-kill MUL result", res, 32'hFFFFFFEB);
        chk("post-kill MUL valid cycle", vcyc, ML);

        // Reset at C5 of a divide
        @(posedge clk); #1;
        funct3 = 3'd4; a = 32'hFFFFFFF9; b = 32'd2; start = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst valid", {31'd0, valid}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        vseen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (valid) vseen++;
        end
        chk("rst no late valid", vseen, 0);

        // start held high through DONE must not restart the op
        @(posedge clk); #1;
        funct3 = 3'd5; a = 32'd100; b = 32'd7; start = 1'b1;
        vcyc = -1; res = 'x;
        for (int n = 1; n <= 33; n++) begin
            @(posedge clk); #2;
            if (valid && vcyc < 0) begin vcyc = n; res = result; end
        end
        chk("held start valid cycle", vcyc, 33);
        chk("held start result", res, 32'd14);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("held start busy after DONE", {31'd0, busy}, 32'd0);
        chk("held start valid after DONE", {31'd0, valid}, 32'd0);
        vseen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (valid) vseen++;
        end
        chk("held start no restart", vseen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
